// File: rtl/l4_control.sv
// Purpose: multi-cycle control FSM for a small load/store CPU (fetch, decode, execute/memory, halt).
// Latency: ALU/MOV 3 cycles, LOAD/STORE 3 cycles, JMP/BEQZ/NOP 2 cycles, plus 1 per mem_ready=0 cycle.
// Backpressure: FETCH and MEM hold their requests until mem_ready=1; mem_ready is ignored in other states.
module l4_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [3:0]       dest_reg,
    input  logic [3:0]       src_reg1,
    input  logic [3:0]       src_reg2,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             IRin,
    output logic             PCinc,
    output logic             PCload,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             addr_sel,
    output logic [2:0]       alu_op,
    output logic             rf_we,
    output logic             wb_sel,
    output logic [3:0]       rf_waddr,
    output logic [3:0]       rf_raddr1,
    output logic [3:0]       rf_raddr2,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_JMP   = 4'd10;
    localparam logic [3:0] OP_NOP   = 4'd11;
    localparam logic [3:0] OP_BEQZ  = 4'd12;
    localparam logic [3:0] OP_MOV   = 4'd13;
    localparam logic [3:0] OP_HALT  = 4'd14;
    localparam logic [3:0] OP_ILL   = 4'd15;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic               halted_q, halted_d;
    logic               retire;

    // Opcode class flags, shared by the decode and execute stages
    logic is_alu, is_mov, is_load, is_store;

    // Register-file addresses come straight from the instruction register fields
    assign rf_waddr  = dest_reg;
    assign rf_raddr1 = src_reg1;
    assign rf_raddr2 = src_reg2;

    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

    // Classify the current opcode
    always_comb begin
        is_alu   = (opcode[3] == 1'b0);
        is_mov   = (opcode == OP_MOV);
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
    end

    // Next-state and strobe generation; reset forces every strobe low
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        IRin      = 1'b0;
        PCinc     = 1'b0;
        PCload    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        addr_sel  = 1'b0;
        alu_op    = 3'd0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        IRin    = 1'b1;
                        PCinc   = 1'b1;
                        state_d = S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (is_alu || is_mov) begin
                        state_d = S_EXEC;
                    end else if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else begin
                        // Control-flow, NOP, HALT and illegal all retire here
                        retire = 1'b1;
                        case (opcode)
                            OP_JMP: begin
                                PCload  = 1'b1;
                                state_d = S_FETCH;
                            end
                            OP_BEQZ: begin
                                PCload  = zero_flag;
                                state_d = S_FETCH;
                            end
                            OP_NOP: begin
                                state_d = S_FETCH;
                            end
                            OP_HALT: begin
                                state_d = S_HALT;
                            end
                            OP_ILL: begin
                                illegal_d = 1'b1;
                                state_d   = S_HALT;
                            end
                            default: begin
                                state_d = S_FETCH;
                            end
                        endcase
                    end
                end

                S_EXEC: begin
                    // MOV passes read port 1 through the ALU using function 0
                    alu_op  = is_mov ? 3'd0 : opcode[2:0];
                    rf_we   = 1'b1;
                    wb_sel  = 1'b0;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end

                S_MEM: begin
                    addr_sel = 1'b1;
                    mem_rd   = is_load;
                    mem_wr   = is_store;
                    if (mem_ready) begin
                        rf_we   = is_load;
                        wb_sel  = is_load;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end

                S_HALT: begin
                    state_d = S_HALT;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // Retired-instruction counter wraps naturally at all-ones
    always_comb begin
        cnt_d = retire ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    // Halted flag tracks entry into the HALT state
    always_comb begin
        halted_d = (state_d == S_HALT);
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

endmodule

// File: tb/tb_l4_control.sv
// Purpose: self-checking bench for l4_control, directed scenarios plus a random instruction stream.
// Latency: inputs change after each falling edge, outputs are sampled 1 ns later.
// Backpressure: mem_ready wait states are inserted randomly in FETCH and MEM.
module tb_l4_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] opcode, dest_reg, src_reg1, src_reg2;
    logic       zero_flag, mem_ready;

    logic        IRin, PCinc, PCload, mem_rd, mem_wr, addr_sel, rf_we, wb_sel, halted, illegal;
    logic [2:0]  alu_op;
    logic [3:0]  rf_waddr, rf_raddr1, rf_raddr2;
    logic [15:0] instr_count;

    logic        n_IRin, n_PCinc, n_PCload, n_mem_rd, n_mem_wr, n_addr_sel, n_rf_we, n_wb_sel;
    logic        n_halted, n_illegal;
    logic [2:0]  n_alu_op;
    logic [3:0]  n_rf_waddr, n_rf_raddr1, n_rf_raddr2;
    logic [3:0]  n_instr_count;

    l4_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .dest_reg(dest_reg), .src_reg1(src_reg1),
        .src_reg2(src_reg2), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .IRin(IRin), .PCinc(PCinc), .PCload(PCload), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr_sel(addr_sel), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
        .rf_waddr(rf_waddr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    l4_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .dest_reg(dest_reg), .src_reg1(src_reg1),
        .src_reg2(src_reg2), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .IRin(n_IRin), .PCinc(n_PCinc), .PCload(n_PCload), .mem_rd(n_mem_rd), .mem_wr(n_mem_wr),
        .addr_sel(n_addr_sel), .alu_op(n_alu_op), .rf_we(n_rf_we), .wb_sel(n_wb_sel),
        .rf_waddr(n_rf_waddr), .rf_raddr1(n_rf_raddr1), .rf_raddr2(n_rf_raddr2),
        .halted(n_halted), .illegal(n_illegal), .instr_count(n_instr_count)
    );

    wire [10:0] obs = {IRin, PCinc, PCload, mem_rd, mem_wr, addr_sel, alu_op, rf_we, wb_sel};

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rdy;
        logic       zf;
        logic [3:0] op;
        logic [10:0] v;
        logic       ret;
    } cyc_t;

    // Expected strobe vector in the same bit order as obs
    function automatic logic [10:0] sv(input logic ir, input logic pc, input logic pl,
                                       input logic rd, input logic wr, input logic as_,
                                       input logic [2:0] alu, input logic we, input logic wb);
        return {ir, pc, pl, rd, wr, as_, alu, we, wb};
    endfunction

    // Apply one cycle of inputs after the falling edge and let outputs settle
    task automatic drive(input logic r, input logic [3:0] op, input logic rdy,
                         input logic zf, input logic [3:0] d);
        @(negedge clk);
        rst       = r;
        opcode    = op;
        mem_ready = rdy;
        zero_flag = zf;
        dest_reg  = d;
        src_reg1  = 4'($urandom_range(0, 15));
        src_reg2  = 4'($urandom_range(0, 15));
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'd0, 1'b1, 1'b0, 4'd0);
        drive(1'b1, 4'd8, 1'b1, 1'b1, 4'd0);
        n_cmp++;
        if (obs !== 11'd0) begin n_bad++; $display("FAIL reset_strobes got %h want %h", obs, 11'd0); end
        n_cmp++;
        if ({halted, illegal, instr_count} !== 18'd0) begin
            n_bad++; $display("FAIL reset_flags got %h want 0", {halted, illegal, instr_count});
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        n_cmp++;
        if (obs !== sv(0,0,0,1,0,0,3'd0,0,0)) begin
            n_bad++; $display("FAIL reset_first_fetch got %h want %h", obs, sv(0,0,0,1,0,0,3'd0,0,0));
        end
    endtask

    task automatic test_alu();
        drive(1'b1, 4'd0, 1'b1, 1'b0, 4'd3);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd3);
        n_cmp++;
        if (obs !== sv(1,1,0,1,0,0,3'd0,0,0)) begin
            n_bad++; $display("FAIL alu_c1 got %h want %h", obs, sv(1,1,0,1,0,0,3'd0,0,0));
        end
        drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd3);
        n_cmp++;
        if (obs !== 11'd0) begin n_bad++; $display("FAIL alu_c2 got %h want 0", obs); end
        drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd3);
        n_cmp++;
        if (obs !== sv(0,0,0,0,0,0,3'd0,1,0) || instr_count !== 16'd0) begin
            n_bad++; $display("FAIL alu_c3 got %h cnt %0d want %h cnt 0", obs, instr_count, sv(0,0,0,0,0,0,3'd0,1,0));
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd3);
        n_cmp++;
        if (instr_count !== 16'd1) begin n_bad++; $display("FAIL alu_count got %0d want 1", instr_count); end
    endtask

    task automatic test_load_wait();
        drive(1'b1, 4'd8, 1'b1, 1'b0, 4'd5);
        drive(1'b0, 4'd8, 1'b1, 1'b0, 4'd5);
        drive(1'b0, 4'd8, 1'b1, 1'b0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd8, (i == 2), 1'b0, 4'd5);
            n_cmp++;
            if (obs !== sv(0,0,0,1,0,1,3'd0,(i == 2),(i == 2)) || rf_waddr !== 4'd5) begin
                n_bad++;
                $display("FAIL load_mem%0d got %h waddr %0d want %h waddr 5", i, obs, rf_waddr,
                         sv(0,0,0,1,0,1,3'd0,(i == 2),(i == 2)));
            end
        end
        drive(1'b0, 4'd8, 1'b0, 1'b0, 4'd5);
        n_cmp++;
        if (obs !== sv(0,0,0,1,0,0,3'd0,0,0) || instr_count !== 16'd1) begin
            n_bad++; $display("FAIL load_after got %h cnt %0d want %h cnt 1", obs, instr_count, sv(0,0,0,1,0,0,3'd0,0,0));
        end
    endtask

    task automatic test_beqz();
        drive(1'b1, 4'd12, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'd12, 1'b1, 1'b0, 4'd0);
            drive(1'b0, 4'd12, 1'b1, (i == 0), 4'd0);
            n_cmp++;
            if (obs !== sv(0,0,(i == 0),0,0,0,3'd0,0,0)) begin
                n_bad++; $display("FAIL beqz_decode%0d got %h want %h", i, obs, sv(0,0,(i == 0),0,0,0,3'd0,0,0));
            end
        end
        drive(1'b0, 4'd12, 1'b1, 1'b0, 4'd0);
        n_cmp++;
        if (obs !== sv(1,1,0,1,0,0,3'd0,0,0) || instr_count !== 16'd2) begin
            n_bad++; $display("FAIL beqz_return got %h cnt %0d want %h cnt 2", obs, instr_count, sv(1,1,0,1,0,0,3'd0,0,0));
        end
    endtask

    task automatic test_illegal_halt(input logic [3:0] op);
        drive(1'b1, op, 1'b1, 1'b0, 4'd0);
        drive(1'b0, op, 1'b1, 1'b0, 4'd0);
        drive(1'b0, op, 1'b1, 1'b0, 4'd0);
        n_cmp++;
        if (obs !== 11'd0 || {halted, illegal} !== 2'b00) begin
            n_bad++; $display("FAIL halt_decode op%0d got %h hi %b want 0 00", op, obs, {halted, illegal});
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b1, 4'd0);
            n_cmp++;
            if (obs !== 11'd0 || {halted, illegal} !== {1'b1, (op == 4'd15)} || instr_count !== 16'd1) begin
                n_bad++;
                $display("FAIL halted op%0d got %h hi %b cnt %0d want 0 %b cnt 1", op, obs,
                         {halted, illegal}, instr_count, {1'b1, (op == 4'd15)});
            end
        end
        drive(1'b1, 4'd0, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        n_cmp++;
        if (obs !== sv(0,0,0,1,0,0,3'd0,0,0) || {halted, illegal} !== 2'b00 || instr_count !== 16'd0) begin
            n_bad++; $display("FAIL halt_rst op%0d got %h hi %b cnt %0d", op, obs, {halted, illegal}, instr_count);
        end
    endtask

    task automatic test_store_reset();
        drive(1'b1, 4'd11, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 4'd11, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 4'd11, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 4'd9, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 4'd9, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'd9, 1'b0, 1'b0, 4'd0);
            n_cmp++;
            if (obs !== sv(0,0,0,0,1,1,3'd0,0,0) || instr_count !== 16'd1) begin
                n_bad++; $display("FAIL store_mem%0d got %h cnt %0d want %h cnt 1", i, obs, instr_count, sv(0,0,0,0,1,1,3'd0,0,0));
            end
        end
        drive(1'b1, 4'd9, 1'b1, 1'b0, 4'd0);
        n_cmp++;
        if (obs !== 11'd0) begin n_bad++; $display("FAIL store_in_rst got %h want 0", obs); end
        drive(1'b0, 4'd9, 1'b0, 1'b0, 4'd0);
        n_cmp++;
        if (obs !== sv(0,0,0,1,0,0,3'd0,0,0) || instr_count !== 16'd0) begin
            n_bad++; $display("FAIL store_after_rst got %h cnt %0d want %h cnt 0", obs, instr_count, sv(0,0,0,1,0,0,3'd0,0,0));
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 4'd11, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd11, 1'b1, 1'b0, 4'd0);
            drive(1'b0, 4'd11, 1'b1, 1'b0, 4'd0);
            n_cmp++;
            if (n_instr_count !== 4'(i)) begin
                n_bad++; $display("FAIL wrap_step%0d got %0d want %0d", i, n_instr_count, i);
            end
        end
        drive(1'b0, 4'd11, 1'b0, 1'b0, 4'd0);
        n_cmp++;
        if (n_instr_count !== 4'd0 || instr_count !== 16'd16) begin
            n_bad++; $display("FAIL wrap_end got %0d/%0d want 0/16", n_instr_count, instr_count);
        end
    endtask

    task automatic test_random();
        cyc_t       q[$];
        cyc_t       c;
        int         cnt_m;
        logic [3:0] op;
        logic       zf;
        int         fw, mw;

        for (int k = 0; k < 80; k++) begin
            op = 4'($urandom_range(0, 13));
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            for (int w = 0; w < fw; w++)
                q.push_back('{1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                              sv(0,0,0,1,0,0,3'd0,0,0), 1'b0});
            q.push_back('{1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          sv(1,1,0,1,0,0,3'd0,0,0), 1'b0});
            zf = 1'($urandom_range(0, 1));
            q.push_back('{1'($urandom_range(0, 1)), zf, op,
                          sv(0,0,(op == 10) || (op == 12 && zf),0,0,0,3'd0,0,0),
                          (op == 10) || (op == 11) || (op == 12)});
            if (op <= 7 || op == 13)
                q.push_back('{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op,
                              sv(0,0,0,0,0,0,(op == 13) ? 3'd0 : op[2:0],1,0), 1'b1});
            if (op == 8 || op == 9) begin
                for (int w = 0; w < mw; w++)
                    q.push_back('{1'b0, 1'($urandom_range(0, 1)), op,
                                  sv(0,0,0,(op == 8),(op == 9),1,3'd0,0,0), 1'b0});
                q.push_back('{1'b1, 1'($urandom_range(0, 1)), op,
                              sv(0,0,0,(op == 8),(op == 9),1,3'd0,(op == 8),(op == 8)), 1'b1});
            end
        end

        cnt_m = 0;
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive(1'b0, c.op, c.rdy, c.zf, 4'($urandom_range(0, 15)));
            n_cmp++;
            if (obs !== c.v) begin
                n_bad++; $display("FAIL rand_strobes op%0d got %h want %h", c.op, obs, c.v);
            end
            n_cmp++;
            if (instr_count !== 16'(cnt_m) || n_instr_count !== 4'(cnt_m)) begin
                n_bad++; $display("FAIL rand_count got %0d/%0d want %0d", instr_count, n_instr_count, cnt_m);
            end
            n_cmp++;
            if ({rf_waddr, rf_raddr1, rf_raddr2, halted, illegal} !== {dest_reg, src_reg1, src_reg2, 2'b00}) begin
                n_bad++; $display("FAIL rand_pass got %h want %h", {rf_waddr, rf_raddr1, rf_raddr2, halted, illegal},
                                  {dest_reg, src_reg1, src_reg2, 2'b00});
            end
            if (c.ret) cnt_m++;
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 4'd0; dest_reg = 4'd0; src_reg1 = 4'd0; src_reg2 = 4'd0;
        zero_flag = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_alu();
        test_load_wait();
        test_beqz();
        test_illegal_halt(4'd15);
        test_illegal_halt(4'd14);
        test_store_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
